// File: rtl/pb_imem_streamload.sv
// Single-clock instruction memory with a streaming loader front-end.
// A loader streams a block of words in over a valid/ready handshake. The
// write address auto-increments, the length is checked against the memory
// size, and an XOR checksum is accumulated. Core fetches are blocked while
// a load is in flight. The array has no reset and exactly one write port
// and one registered read port, so it maps onto block RAM.
module pb_imem_streamload #(
    parameter  int DATA_W    = 32,
    parameter  int MEM_DEPTH = 64,
    localparam int ADDR_W    = $clog2(MEM_DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              fetch_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    input  logic              load_start_i,
    input  logic [ADDR_W-1:0] load_base_i,
    input  logic [ADDR_W:0]   load_len_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              load_valid_i,
    output logic              load_ready_o,
    output logic              load_busy_o,
    output logic              load_done_o,
    output logic              load_err_o,
    output logic [ADDR_W:0]   load_count_o,
    output logic [DATA_W-1:0] load_csum_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Depth at two widths: one for fetch-address range checks, one wide
    // enough to hold base+len without overflow.
    localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W+1:0] DEPTH_L = (ADDR_W+2)'(MEM_DEPTH);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic [1:0]        state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W+1:0] load_end;
    logic              load_bad;
    logic              wr_en;

    assign load_end = {2'b00, load_base_i} + {1'b0, load_len_i};
    assign load_bad = (load_len_i == '0) || (load_end > DEPTH_L);

    // A word is written only on a live handshake; a reset edge suppresses it
    // so an aborted load cannot sneak in one more word.
    assign wr_en = !rst_i && (state == ST_LOAD) && load_valid_i;

    assign load_ready_o = (state == ST_LOAD);
    assign load_busy_o  = (state != ST_IDLE);
    assign load_done_o  = (state == ST_DONE);

    // Memory write port: no reset so the array stays block-RAM friendly.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_addr] <= load_data_i;
        end
    end

    // Registered fetch port, served only while no load is in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_o       <= '0;
            data_valid_o <= 1'b0;
        end else if (fetch_en_i && (state == ST_IDLE)) begin
            data_valid_o <= 1'b1;
            if ({1'b0, addr_i} >= DEPTH_A) begin
                data_o <= '0;
            end else begin
                data_o <= mem[addr_i];
            end
        end else begin
            data_valid_o <= 1'b0;
        end
    end

    // Loader FSM: command check, word counting, checksum and sticky error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            wr_addr      <= '0;
            remaining    <= '0;
            load_count_o <= '0;
            load_csum_o  <= '0;
            load_err_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_start_i) begin
                        if (load_bad) begin
                            load_err_o <= 1'b1;
                        end else begin
                            wr_addr      <= load_base_i;
                            remaining    <= load_len_i;
                            load_count_o <= '0;
                            load_csum_o  <= '0;
                            load_err_o   <= 1'b0;
                            state        <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (load_valid_i) begin
                        wr_addr      <= wr_addr + 1'b1;
                        remaining    <= remaining - 1'b1;
                        load_count_o <= load_count_o + 1'b1;
                        load_csum_o  <= load_csum_o ^ load_data_i;
                        if (remaining == {{ADDR_W{1'b0}}, 1'b1}) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pb_imem_streamload.sv
// Directed bench for pb_imem_streamload: a vector table for the basic load,
// fetch and reject flows, plus hand-written multi-cycle sequences for
// stalled loads, fetch blocking, reset mid-load and a narrow/odd-depth build.
module tb_pb_imem_streamload;

    logic        clk;
    logic        rst;
    logic        fetch_en;
    logic [5:0]  addr;
    logic [31:0] data;
    logic        data_valid;
    logic        load_start;
    logic [5:0]  load_base;
    logic [6:0]  load_len;
    logic [31:0] load_data;
    logic        load_valid;
    logic        load_ready;
    logic        load_busy;
    logic        load_done;
    logic        load_err;
    logic [6:0]  load_count;
    logic [31:0] load_csum;

    // Second build: 16-bit words, 40-word memory (still 6 address bits).
    logic        s_rst;
    logic        s_fetch_en;
    logic [5:0]  s_addr;
    logic [15:0] s_data;
    logic        s_data_valid;
    logic        s_load_start;
    logic [5:0]  s_load_base;
    logic [6:0]  s_load_len;
    logic [15:0] s_load_data;
    logic        s_load_valid;
    logic        s_load_ready;
    logic        s_load_busy;
    logic        s_load_done;
    logic        s_load_err;
    logic [6:0]  s_load_count;
    logic [15:0] s_load_csum;

    int checks;
    int errors;

    pb_imem_streamload #(.DATA_W(32), .MEM_DEPTH(64)) u_dut (
        .clk_i(clk), .rst_i(rst), .fetch_en_i(fetch_en), .addr_i(addr),
        .data_o(data), .data_valid_o(data_valid),
        .load_start_i(load_start), .load_base_i(load_base), .load_len_i(load_len),
        .load_data_i(load_data), .load_valid_i(load_valid), .load_ready_o(load_ready),
        .load_busy_o(load_busy), .load_done_o(load_done), .load_err_o(load_err),
        .load_count_o(load_count), .load_csum_o(load_csum)
    );

    pb_imem_streamload #(.DATA_W(16), .MEM_DEPTH(40)) u_small (
        .clk_i(clk), .rst_i(s_rst), .fetch_en_i(s_fetch_en), .addr_i(s_addr),
        .data_o(s_data), .data_valid_o(s_data_valid),
        .load_start_i(s_load_start), .load_base_i(s_load_base), .load_len_i(s_load_len),
        .load_data_i(s_load_data), .load_valid_i(s_load_valid), .load_ready_o(s_load_ready),
        .load_busy_o(s_load_busy), .load_done_o(s_load_done), .load_err_o(s_load_err),
        .load_count_o(s_load_count), .load_csum_o(s_load_csum)
    );

    // Free-running clock shared by both instances.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        fen;
        logic [5:0]  addr;
        logic        start;
        logic [5:0]  base;
        logic [6:0]  len;
        logic        valid;
        logic [31:0] data;
        logic        exp_dv;
        logic [31:0] exp_dout;
        logic        exp_rdy;
        logic        exp_busy;
        logic        exp_done;
        logic        exp_err;
        logic [6:0]  exp_cnt;
        logic [31:0] exp_csum;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input int r, input int f, input int a, input int s,
                                input int b, input int l, input int v, input logic [31:0] d,
                                input int edv, input logic [31:0] ed, input int erdy,
                                input int ebusy, input int edone, input int eerr,
                                input int ecnt, input logic [31:0] ecs);
        vec_t m;
        m.rst      = r[0];
        m.fen      = f[0];
        m.addr     = a[5:0];
        m.start    = s[0];
        m.base     = b[5:0];
        m.len      = l[6:0];
        m.valid    = v[0];
        m.data     = d;
        m.exp_dv   = edv[0];
        m.exp_dout = ed;
        m.exp_rdy  = erdy[0];
        m.exp_busy = ebusy[0];
        m.exp_done = edone[0];
        m.exp_err  = eerr[0];
        m.exp_cnt  = ecnt[6:0];
        m.exp_csum = ecs;
        return m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        rst        = v.rst;
        fetch_en   = v.fen;
        addr       = v.addr;
        load_start = v.start;
        load_base  = v.base;
        load_len   = v.len;
        load_valid = v.valid;
        load_data  = v.data;
        tick();
    endtask

    task automatic check_status(input string tag, input int busy, input int done,
                                input int err, input int cnt, input logic [31:0] csum);
        check_output({tag, ".busy"}, 32'(load_busy), 32'(busy));
        check_output({tag, ".done"}, 32'(load_done), 32'(done));
        check_output({tag, ".err"},  32'(load_err),  32'(err));
        check_output({tag, ".cnt"},  32'(load_count), 32'(cnt));
        check_output({tag, ".csum"}, load_csum, csum);
    endtask

    task automatic start_load(input int base, input int len);
        load_start = 1'b1;
        load_base  = base[5:0];
        load_len   = len[6:0];
        tick();
        load_start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] w);
        load_valid = 1'b1;
        load_data  = w;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic fetch_check(input string tag, input int a, input logic [31:0] exp);
        fetch_en = 1'b1;
        addr     = a[5:0];
        tick();
        fetch_en = 1'b0;
        check_output({tag, ".dv"},   32'(data_valid), 32'd1);
        check_output({tag, ".data"}, data, exp);
    endtask

    task automatic s_fetch_check(input string tag, input int a, input logic [15:0] exp);
        s_fetch_en = 1'b1;
        s_addr     = a[5:0];
        tick();
        s_fetch_en = 1'b0;
        check_output({tag, ".dv"},   32'(s_data_valid), 32'd1);
        check_output({tag, ".data"}, 32'(s_data), 32'(exp));
    endtask

    // Main test sequence.
    initial begin
        logic [31:0] words [4];
        logic [15:0] s_words [4];
        logic [31:0] exp_csum;
        int          exp_cnt;

        checks = 0;
        errors = 0;
        words[0] = 32'h11111111; words[1] = 32'h22222222;
        words[2] = 32'h44444444; words[3] = 32'h88888888;
        s_words[0] = 16'h1111; s_words[1] = 16'h2222;
        s_words[2] = 16'h4444; s_words[3] = 16'h8888;

        rst = 1'b1; fetch_en = 1'b0; addr = '0; load_start = 1'b0;
        load_base = '0; load_len = '0; load_data = '0; load_valid = 1'b0;
        s_rst = 1'b1; s_fetch_en = 1'b0; s_addr = '0; s_load_start = 1'b0;
        s_load_base = '0; s_load_len = '0; s_load_data = '0; s_load_valid = 1'b0;

        //              rst fen adr st bas len vl data          dv dout          rdy bsy dn er cnt csum
        vecs[0]  = mk(1, 0, 0,  0, 0,  0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 0, 32'h0);
        vecs[1]  = mk(0, 0, 0,  1, 10, 4, 0, 32'h0,        0, 32'h0,        1, 1, 0, 0, 0, 32'h0);
        vecs[2]  = mk(0, 0, 0,  0, 0,  0, 1, 32'h11111111, 0, 32'h0,        1, 1, 0, 0, 1, 32'h11111111);
        vecs[3]  = mk(0, 0, 0,  0, 0,  0, 1, 32'h22222222, 0, 32'h0,        1, 1, 0, 0, 2, 32'h33333333);
        vecs[4]  = mk(0, 0, 0,  0, 0,  0, 1, 32'h44444444, 0, 32'h0,        1, 1, 0, 0, 3, 32'h77777777);
        vecs[5]  = mk(0, 0, 0,  0, 0,  0, 1, 32'h88888888, 0, 32'h0,        0, 1, 1, 0, 4, 32'hFFFFFFFF);
        vecs[6]  = mk(0, 1, 10, 0, 0,  0, 0, 32'h0,        0, 32'h0,        0, 0, 0, 0, 4, 32'hFFFFFFFF);
        vecs[7]  = mk(0, 1, 10, 0, 0,  0, 0, 32'h0,        1, 32'h11111111, 0, 0, 0, 0, 4, 32'hFFFFFFFF);
        vecs[8]  = mk(0, 1, 11, 0, 0,  0, 0, 32'h0,        1, 32'h22222222, 0, 0, 0, 0, 4, 32'hFFFFFFFF);
        vecs[9]  = mk(0, 1, 12, 0, 0,  0, 0, 32'h0,        1, 32'h44444444, 0, 0, 0, 0, 4, 32'hFFFFFFFF);
        vecs[10] = mk(0, 1, 13, 0, 0,  0, 0, 32'h0,        1, 32'h88888888, 0, 0, 0, 0, 4, 32'hFFFFFFFF);
        vecs[11] = mk(0, 0, 0,  0, 0,  0, 0, 32'h0,        0, 32'h88888888, 0, 0, 0, 0, 4, 32'hFFFFFFFF);
        vecs[12] = mk(0, 0, 0,  1, 62, 3, 0, 32'h0,        0, 32'h88888888, 0, 0, 0, 1, 4, 32'hFFFFFFFF);
        vecs[13] = mk(0, 0, 0,  1, 62, 2, 0, 32'h0,        0, 32'h88888888, 1, 1, 0, 0, 0, 32'h0);
        vecs[14] = mk(0, 0, 0,  0, 0,  0, 1, 32'hA5A5A5A5, 0, 32'h88888888, 1, 1, 0, 0, 1, 32'hA5A5A5A5);
        vecs[15] = mk(0, 0, 0,  0, 0,  0, 1, 32'h0F0F0F0F, 0, 32'h88888888, 0, 1, 1, 0, 2, 32'hAAAAAAAA);
        vecs[16] = mk(0, 0, 0,  0, 0,  0, 0, 32'h0,        0, 32'h88888888, 0, 0, 0, 0, 2, 32'hAAAAAAAA);
        vecs[17] = mk(0, 1, 63, 0, 0,  0, 0, 32'h0,        1, 32'h0F0F0F0F, 0, 0, 0, 0, 2, 32'hAAAAAAAA);
        vecs[18] = mk(0, 0, 0,  1, 0,  0, 0, 32'h0,        0, 32'h0F0F0F0F, 0, 0, 0, 1, 2, 32'hAAAAAAAA);
        vecs[19] = mk(0, 0, 0,  0, 0,  0, 0, 32'h0,        0, 32'h0F0F0F0F, 0, 0, 0, 1, 2, 32'hAAAAAAAA);

        for (int i = 0; i < 20; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            apply_stimulus(vecs[i]);
            check_output({tag, ".dv"},   32'(data_valid), 32'(vecs[i].exp_dv));
            check_output({tag, ".dout"}, data, vecs[i].exp_dout);
            check_output({tag, ".rdy"},  32'(load_ready), 32'(vecs[i].exp_rdy));
            check_status(tag, int'(vecs[i].exp_busy), int'(vecs[i].exp_done),
                         int'(vecs[i].exp_err), int'(vecs[i].exp_cnt), vecs[i].exp_csum);
        end

        // Stalled load: valid toggles every other cycle, err from the len-0
        // reject above must clear on the accepted start.
        start_load(20, 4);
        check_status("stall.start", 1, 0, 0, 0, 32'h0);
        exp_cnt  = 0;
        exp_csum = 32'h0;
        for (int i = 0; i < 7; i++) begin
            load_valid = (i % 2 == 0);
            load_data  = words[i / 2];
            if (load_valid) begin
                exp_cnt++;
                exp_csum ^= words[i / 2];
            end
            tick();
            check_status($sformatf("stall%0d", i), 1, (i == 6) ? 1 : 0, 0, exp_cnt, exp_csum);
        end
        load_valid = 1'b0;
        tick();
        check_status("stall.end", 0, 0, 0, 4, 32'hFFFFFFFF);
        for (int i = 0; i < 4; i++) begin
            fetch_check($sformatf("stall.fetch%0d", i), 20 + i, words[i]);
        end

        // Fetch held high across a load overwriting address 10.
        fetch_en = 1'b1;
        addr     = 6'd10;
        start_load(10, 2);
        check_output("blk.start.dv", 32'(data_valid), 32'd1);
        check_output("blk.start.data", data, 32'h11111111);
        push_word(32'hDEADBEEF);
        check_output("blk.w0.dv", 32'(data_valid), 32'd0);
        check_output("blk.w0.data", data, 32'h11111111);
        push_word(32'hCAFEF00D);
        check_output("blk.w1.dv", 32'(data_valid), 32'd0);
        check_output("blk.w1.done", 32'(load_done), 32'd1);
        tick();
        check_output("blk.done.dv", 32'(data_valid), 32'd0);
        check_output("blk.done.data", data, 32'h11111111);
        tick();
        check_output("blk.resume.dv", 32'(data_valid), 32'd1);
        check_output("blk.resume.data", data, 32'hDEADBEEF);
        fetch_en = 1'b0;
        fetch_check("blk.fetch11", 11, 32'hCAFEF00D);

        // Reset after two of four words; the third address keeps old data.
        start_load(32, 1);
        push_word(32'h12345678);
        tick();
        start_load(30, 4);
        push_word(32'hC0000001);
        push_word(32'hC0000002);
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 32'h99999999;
        tick();
        rst        = 1'b0;
        load_valid = 1'b0;
        check_status("rst", 0, 0, 0, 0, 32'h0);
        check_output("rst.rdy", 32'(load_ready), 32'd0);
        check_output("rst.dv", 32'(data_valid), 32'd0);
        check_output("rst.data", data, 32'h0);
        tick();
        check_status("rst.after", 0, 0, 0, 0, 32'h0);
        fetch_check("rst.fetch30", 30, 32'hC0000001);
        fetch_check("rst.fetch31", 31, 32'hC0000002);
        fetch_check("rst.fetch32", 32, 32'h12345678);

        // Narrow, non-power-of-two build.
        tick();
        s_rst = 1'b0;
        check_output("small.rst.busy", 32'(s_load_busy), 32'd0);
        check_output("small.rst.dv", 32'(s_data_valid), 32'd0);
        s_load_start = 1'b1; s_load_base = 6'd10; s_load_len = 7'd4;
        tick();
        s_load_start = 1'b0;
        check_output("small.start.rdy", 32'(s_load_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            s_load_valid = 1'b1;
            s_load_data  = s_words[i];
            tick();
        end
        s_load_valid = 1'b0;
        check_output("small.done", 32'(s_load_done), 32'd1);
        check_output("small.cnt", 32'(s_load_count), 32'd4);
        check_output("small.csum", 32'(s_load_csum), 32'h0000FFFF);
        tick();
        s_fetch_check("small.fetch10", 10, 16'h1111);
        s_fetch_check("small.fetch13", 13, 16'h8888);
        s_fetch_check("small.fetch45", 45, 16'h0000);
        s_load_start = 1'b1; s_load_base = 6'd38; s_load_len = 7'd3;
        tick();
        s_load_start = 1'b0;
        check_output("small.rej.err", 32'(s_load_err), 32'd1);
        check_output("small.rej.busy", 32'(s_load_busy), 32'd0);
        check_output("small.rej.cnt", 32'(s_load_count), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pb_imem_streamload.md
Name: pb_imem_streamload

Overview:
Parametrised single-clock instruction memory for the RV32I core with a streaming loader front-end. A block of words is streamed in through a valid/ready handshake with auto-incrementing address, length check and XOR checksum. The processor fetch port is blocked while a load is in flight. It replaces the dual-clock test-load memory on single-clock builds, where the external loader (debug/UART bridge) shares the core clock.

Parameters:
DATA_W, 32, word width in bits (any value ≥ 8)
MEM_DEPTH, 64, number of words (need not be a power of two)
ADDR_W, $clog2(MEM_DEPTH), word-address width; derived, never overridden

Ports:
clk_i  in  1  single system clock; all logic on rising edge
rst_i  in  1  synchronous reset, active-high
fetch_en_i  in  1  fetch request from core
addr_i  in  ADDR_W  fetch word address
data_o  out  DATA_W  registered fetch data
data_valid_o  out  1  data_o updated this cycle
load_start_i  in  1  start-load command (single-cycle pulse)
load_base_i  in  ADDR_W  first word address of load
load_len_i  in  ADDR_W+1  number of words to load
load_data_i  in  DATA_W  stream data
load_valid_i  in  1  stream data valid
load_ready_o  out  1  loader accepts a word
load_busy_o  out  1  load in progress (LOAD or DONE state)
load_done_o  out  1  one-cycle pulse when the last word has been written
load_err_o  out  1  sticky: rejected load command
load_count_o  out  ADDR_W+1  words accepted in current/last load
load_csum_o  out  DATA_W  XOR of all words accepted in current/last load

Behaviour:
- Reset (rst_i=1 at an edge): state IDLE. data_o, data_valid_o, load_ready_o, load_busy_o, load_done_o, load_err_o, load_count_o and load_csum_o are all 0. Memory contents are NOT cleared.
- Reset mid-load: the load aborts immediately. Words already written remain in memory. No load_done_o pulse.
- FSM states: IDLE, LOAD, DONE.
- IDLE, load_start_i=1:
  - Reject if load_len_i==0 or load_base_i+load_len_i > MEM_DEPTH (sum computed at ADDR_W+2 bits). On reject: load_err_o<=1, stay IDLE, count/csum unchanged.
  - Otherwise accept: latch wr_addr<=load_base_i, remaining<=load_len_i, load_count_o<=0, load_csum_o<=0, load_err_o<=0, go to LOAD.
- LOAD:
  - load_ready_o=1, driven combinationally from state.
  - On load_valid_i&&load_ready_o: mem[wr_addr]<=load_data_i, wr_addr++, remaining--, load_count_o++, load_csum_o^=load_data_i.
  - On the handshake where remaining==1: go to DONE.
  - load_valid_i low stalls the load indefinitely; there is no timeout.
  - load_start_i is ignored in LOAD and DONE.
- DONE: lasts one cycle. load_done_o=1, load_ready_o=0, then go to IDLE.
- load_busy_o = (state != IDLE).
- Fetch, one-cycle latency:
  - At an edge with fetch_en_i=1 and state==IDLE: data_o<=mem[addr_i], data_valid_o<=1.
  - If addr_i ≥ MEM_DEPTH: data_o<=0, data_valid_o<=1.
  - Otherwise data_valid_o<=0 and data_o holds its value.
  - A fetch in the same cycle as an accepted load_start_i is still served, because state is IDLE at that edge.
- A write and a read never occur in the same cycle, so there is no read-during-write hazard.
- The memory array must infer block RAM: one write port, one registered read port, no reset on the array.
- load_count_o and load_csum_o hold their final values after DONE until the next accepted load or reset.

Test Plan:
- Load 4 words 0x11111111, 0x22222222, 0x44444444, 0x88888888 at base 10, len 4, valid held high → ready high 4 cycles. load_done_o pulses 1 cycle after 4th handshake. count=4, csum=0xFFFFFFFF. Fetches at 10..13 return the words, one cycle after each request.
- Same load with load_valid_i toggled every other cycle → exactly 4 writes, identical memory contents and csum. busy is held throughout.
- load_start_i with base 62, len 3 (MEM_DEPTH=64) → load_err_o=1, state stays IDLE, memory unchanged. Next load with base 62, len 2 is accepted and clears err.
- load_start_i with len 0 → err=1, no busy, no done.
- fetch_en_i held high during a load → data_valid_o=0 while busy, data_o unchanged. Fetch resumes the first cycle after done; mem[10] fetch returns the newly written value.
- rst_i asserted after 2 of 4 words → outputs 0 next cycle, no done. Fetch of the 2 written words returns the new data; the 3rd address returns its old contents.
- Rerun the first scenario with DATA_W=16, MEM_DEPTH=40 → ADDR_W=6. Fetch at address 45 returns 0 with data_valid_o=1.
